// File: rtl/spram_pkg.sv
// Shared constants, FSM state type and a constant clog2 helper for the SPRAM bank memory.
package spram_pkg;

    localparam int unsigned SPRAM_DEPTH = 16384;
    localparam int unsigned SPRAM_W     = 16;
    localparam int unsigned SPRAM_ROW_W = 14;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40UP5K 16K x 16 single-port RAM with nibble write masks.
module SB_SPRAM256KA (
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        CLOCK,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);

    logic [15:0] r_mem [0:16383];

    // POWEROFF is active low on the real part: 1 keeps the array powered.
    always_ff @(posedge CLOCK) begin
        if (CHIPSELECT && !STANDBY && !SLEEP && POWEROFF) begin
            if (WREN) begin
                for (int unsigned n = 0; n < 4; n++) begin
                    if (MASKWREN[n]) r_mem[ADDRESS][n*4 +: 4] <= DATAIN[n*4 +: 4];
                end
            end else begin
                DATAOUT <= r_mem[ADDRESS];
            end
        end
    end

endmodule

// File: rtl/spram_lane_row.sv
// One depth bank: LANES = DATA_W/16 SPRAM primitives side by side, lane 0 at the LSB.
module spram_lane_row
    import spram_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                   i_clk,
    input  logic [SPRAM_ROW_W-1:0] i_row,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic [DATA_W/8-1:0]    i_be,
    input  logic                   i_we,
    output logic [DATA_W-1:0]      o_rdata
);

    localparam int unsigned LANES = DATA_W / SPRAM_W;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [3:0] w_mask;
        assign w_mask = {i_be[2*k+1], i_be[2*k+1], i_be[2*k], i_be[2*k]};

        SB_SPRAM256KA u_spram (
            .ADDRESS    (i_row),
            .DATAIN     (i_wdata[k*SPRAM_W +: SPRAM_W]),
            .MASKWREN   (w_mask),
            .WREN       (i_we),
            .CHIPSELECT (1'b1),
            .CLOCK      (i_clk),
            .STANDBY    (1'b0),
            .SLEEP      (1'b0),
            .POWEROFF   (1'b1),
            .DATAOUT    (o_rdata[k*SPRAM_W +: SPRAM_W])
        );
    end

endmodule

// File: rtl/spram_bank_memory.sv
// Width/depth-cascaded SPRAM store with post-reset clear and valid/ready port.
// Define SPRAM_OUTREG_EN to add an output register after the bank mux (2-cycle read latency).
module spram_bank_memory
    import spram_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_BANKS = 1,
    parameter int unsigned ADDR_W    = 14 + clog2(DATA_W/8) + clog2(NUM_BANKS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                init_done
);

    localparam int unsigned OFF_W     = clog2(DATA_W/8);
    localparam int unsigned BANK_BITS = clog2(NUM_BANKS);
    localparam int unsigned BANK_W    = (BANK_BITS == 0) ? 1 : BANK_BITS;
    localparam int unsigned WORD_W    = SPRAM_ROW_W + BANK_BITS;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SPRAM_ROW_W-1:0] r_cnt;

    logic [WORD_W-1:0]      w_word;
    logic [SPRAM_ROW_W-1:0] w_row;
    logic [BANK_W-1:0]      w_bank;
    logic                   w_oob;
    logic                   w_accept;
    logic                   w_rd_accept;
    logic                   w_unused_addr;

    logic [SPRAM_ROW_W-1:0] w_row_mux;
    logic [DATA_W-1:0]      w_wdata_mux;
    logic [DATA_W/8-1:0]    w_be_mux;
    logic [NUM_BANKS-1:0]   w_bank_we;
    logic [DATA_W-1:0]      w_bank_rdata [NUM_BANKS];
    logic [DATA_W-1:0]      w_bank_sel;

    logic                   r_rd_q;
    logic [BANK_W-1:0]      r_bank_q;
    logic                   r_oob_q;
    logic [DATA_W-1:0]      r_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) r_cnt <= r_cnt + 14'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == CLEAR && r_cnt == SPRAM_ROW_W'(SPRAM_DEPTH - 1)) w_state_next = READY;
    end

    assign req_ready = (r_state == READY);
    assign init_done = (r_state == READY);

    assign w_word        = req_addr[ADDR_W-1:OFF_W];
    assign w_row         = w_word[SPRAM_ROW_W-1:0];
    assign w_unused_addr = ^req_addr[OFF_W-1:0];

    if (BANK_BITS == 0) begin : g_one_bank
        assign w_bank = '0;
    end else begin : g_multi_bank
        assign w_bank = w_word[WORD_W-1:SPRAM_ROW_W];
    end

    assign w_oob       = (32'(w_bank) >= NUM_BANKS);
    assign w_accept    = req_valid && req_ready;
    assign w_rd_accept = w_accept && !req_we;

    // During CLEAR every bank is written at row r_cnt with zero data and full masks.
    always_comb begin
        w_row_mux   = (r_state == CLEAR) ? r_cnt : w_row;
        w_wdata_mux = (r_state == CLEAR) ? '0 : req_wdata;
        w_be_mux    = (r_state == CLEAR) ? '1 : req_be;
        w_bank_we   = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            w_bank_we[b] = (r_state == CLEAR) ||
                           (w_accept && req_we && (w_bank == BANK_W'(b)));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        spram_lane_row #(
            .DATA_W (DATA_W)
        ) u_row (
            .i_clk   (clk),
            .i_row   (w_row_mux),
            .i_wdata (w_wdata_mux),
            .i_be    (w_be_mux),
            .i_we    (w_bank_we[b]),
            .o_rdata (w_bank_rdata[b])
        );
    end

    always_comb begin
        w_bank_sel = '0;
        if (!r_oob_q) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (r_bank_q == BANK_W'(b)) w_bank_sel = w_bank_rdata[b];
            end
        end
    end

`ifdef SPRAM_OUTREG_EN
    logic r_rsp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_q      <= 1'b0;
            r_bank_q    <= '0;
            r_oob_q     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_rd_q      <= w_rd_accept;
            r_rsp_valid <= r_rd_q;
            if (w_rd_accept) begin
                r_bank_q <= w_bank;
                r_oob_q  <= w_oob;
            end
            if (r_rd_q) r_hold <= w_bank_sel;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_hold;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_q   <= 1'b0;
            r_bank_q <= '0;
            r_oob_q  <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_rd_q <= w_rd_accept;
            if (w_rd_accept) begin
                r_bank_q <= w_bank;
                r_oob_q  <= w_oob;
            end
            if (r_rd_q) r_hold <= w_bank_sel;
        end
    end

    // The primitive's DATAOUT moves on every non-write cycle, so the last response is held locally.
    assign rsp_valid = r_rd_q;
    assign rsp_rdata = r_rd_q ? w_bank_sel : r_hold;
`endif

endmodule
